// File: rtl/seq_det_ctrl.sv
// Word-to-serial stream controller with an overlapping pattern matcher, a saturating match counter and a threshold irq.
// Optional build macro SEQ_DET_CTRL_HALT_EN: stall streaming after a word that completes with irq set.
module seq_det_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [CNT_W-1:0]  cfg_threshold,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              irq,
    input  logic              irq_clr,
    output logic              busy
);
    localparam int IDX_W  = $clog2(WORD_W);
    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SEQ_DET_CTRL_HALT_EN
        , HALT
`endif
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pattern;
    logic [CNT_W-1:0]  threshold;

    logic [PAT_W:0]    ext;
    logic [PAT_W-1:0]  cand;
    logic              hit;
    logic              last_bit;
    logic              cfg_ok;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              irq_nxt;

    assign bit_out = shreg[WORD_W-1];

    // The window is formed through a PAT_W+1 wide concat so PAT_W==1 needs no special slice.
    always_comb begin
        ext      = {hist, bit_out};
        cand     = ext[PAT_W-1:0];
        hit      = bit_valid && (fill >= FILL_W'(PAT_W - 1)) && (cand == pattern);
        last_bit = bit_valid && (idx == IDX_W'(WORD_W - 1));
        cfg_ok   = cfg_we && !busy;
        cnt_nxt  = match_count;
        irq_nxt  = irq;
        if (irq_clr) begin
            cnt_nxt = '0;
            irq_nxt = 1'b0;
        end
        // A match in the same cycle as irq_clr counts from zero and may still set irq.
        if (hit) begin
            if (!(&cnt_nxt))
                cnt_nxt = cnt_nxt + 1'b1;
            if ((threshold != '0) && (cnt_nxt == threshold))
                irq_nxt = 1'b1;
        end
        if (cfg_ok) begin
            cnt_nxt = '0;
            irq_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            hist        <= '0;
            fill        <= '0;
            pattern     <= '0;
            threshold   <= '0;
            match_count <= '0;
            irq         <= 1'b0;
            match_pulse <= 1'b0;
            in_ready    <= 1'b1;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            match_pulse <= hit;
            match_count <= cnt_nxt;
            irq         <= irq_nxt;
            if (bit_valid) begin
                hist <= cand;
                if (fill != FILL_W'(PAT_W))
                    fill <= fill + 1'b1;
            end
            // cfg_ok implies no bit in flight, so this never races the history update above.
            if (cfg_ok) begin
                pattern   <= cfg_pattern;
                threshold <= cfg_threshold;
                hist      <= '0;
                fill      <= '0;
            end
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg     <= in_data;
                        idx       <= '0;
                        state     <= SHIFT;
                        in_ready  <= 1'b0;
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    idx   <= idx + 1'b1;
                    if (last_bit) begin
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
`ifdef SEQ_DET_CTRL_HALT_EN
                        if (irq_nxt) begin
                            state    <= HALT;
                            in_ready <= 1'b0;
                        end
`endif
                    end
                end
`ifdef SEQ_DET_CTRL_HALT_EN
                HALT: begin
                    if (irq_clr || cfg_ok) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: expected bits queued on handshake, checked as the DUT drives them.
module tb_seq_det_ctrl;
    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [PAT_W-1:0]  cfg_pattern = '0;
    logic [CNT_W-1:0]  cfg_threshold = '0;
    logic              in_valid = 1'b0;
    logic [WORD_W-1:0] in_data = '0;
    logic              irq_clr = 1'b0;
    logic              in_ready, bit_out, bit_valid, match_pulse, irq, busy;
    logic [CNT_W-1:0]  match_count;

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // reference model state
    bit               exp_q[$];
    logic [PAT_W-1:0] m_hist = '0, m_pat = '0;
    int               m_fill = 0;
    logic [CNT_W-1:0] m_cnt = '0, m_thr = '0;
    bit               m_irq = 1'b0, m_pulse = 1'b0, m_halt = 1'b0;

    always #5 clk = ~clk;

    seq_det_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_threshold(cfg_threshold), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .match_pulse(match_pulse), .match_count(match_count), .irq(irq),
        .irq_clr(irq_clr), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Negedge monitor: compare against model, then advance model with the inputs the next edge will see.
    always @(negedge clk) begin
        bit b, hit, last, was_busy, rdy;
        if (mon_en) begin
            was_busy = (exp_q.size() != 0);
            rdy      = !was_busy && !m_halt;
            chk("bit_valid", bit_valid, was_busy);
            chk("busy", busy, was_busy);
            chk("in_ready", in_ready, rdy);
            if (was_busy) chk("bit_out", bit_out, exp_q[0]);
            chk("match_pulse", match_pulse, m_pulse);
            chk("match_count", match_count, m_cnt);
            chk("irq", irq, m_irq);
            if (reset) begin
                exp_q.delete();
                m_hist = '0; m_pat = '0; m_fill = 0; m_cnt = '0; m_thr = '0;
                m_irq = 1'b0; m_pulse = 1'b0; m_halt = 1'b0;
            end else begin
                hit = 1'b0;
                last = 1'b0;
                if (was_busy) begin
                    b = exp_q.pop_front();
                    hit = (m_fill >= PAT_W - 1) && ({m_hist[PAT_W-2:0], b} == m_pat);
                    m_hist = {m_hist[PAT_W-2:0], b};
                    if (m_fill < PAT_W) m_fill++;
                    last = (exp_q.size() == 0);
                end
                m_pulse = hit;
                if (irq_clr) begin m_cnt = '0; m_irq = 1'b0; end
                if (hit) begin
                    if (m_cnt != '1) m_cnt++;
                    if (m_thr != 0 && m_cnt == m_thr) m_irq = 1'b1;
                end
`ifdef SEQ_DET_CTRL_HALT_EN
                if (m_halt && irq_clr) m_halt = 1'b0;
                if (last && m_irq) m_halt = 1'b1;
`endif
                if (cfg_we && !was_busy) begin
                    m_pat = cfg_pattern; m_thr = cfg_threshold;
                    m_hist = '0; m_fill = 0; m_cnt = '0; m_irq = 1'b0; m_halt = 1'b0;
                end
                if (in_valid && rdy)
                    for (int i = WORD_W - 1; i >= 0; i--) exp_q.push_back(in_data[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, output int waited);
        in_valid = 1'b1;
        in_data  = w;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) chk("handshake_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_data  = WORD_W'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", 0, 1);
    endtask

    task automatic cfg(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t);
        cfg_we = 1'b1; cfg_pattern = p; cfg_threshold = t;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_clr();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_count", match_count, 0);
        chk("rst_irq", irq, 0);
        chk("rst_busy", busy, 0);

        // basic serialisation, two overlapping-window matches
        cfg(4'b1001, 8'd0);
        send_word(8'b1001_0010, w);
        wait_idle();
        chk("basic_count", match_count, 2);

        // cross-word match, and the WORD_W+1 cycle word period
        cfg(4'b1001, 8'd0);
        send_word(8'b0000_0100, w);
        send_word(8'b1000_0000, w);
        chk("ready_gap", w, WORD_W);
        wait_idle();
        chk("cross_count", match_count, 1);

        // threshold irq and clear
        cfg(4'b1001, 8'd2);
        send_word(8'b1001_0010, w);
        wait_idle();
        chk("thr_irq", irq, 1);
        chk("thr_count", match_count, 2);
        pulse_clr();
        chk("clr_irq", irq, 0);
        chk("clr_count", match_count, 0);

        // irq_clr coincident with a match that would otherwise hit threshold
        cfg(4'b1001, 8'd3);
        send_word(8'b1001_0010, w);
        wait_idle();
        send_word(8'b1001_0010, w);
        repeat (3) tick();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("coinc_count", match_count, 1);
        chk("coinc_irq", irq, 0);
        wait_idle();

        // halt after a word that leaves irq set
        cfg(4'b1001, 8'd1);
        send_word(8'b1001_0000, w);
`ifdef SEQ_DET_CTRL_HALT_EN
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (WORD_W + 3) tick();
        chk("halt_ready", in_ready, 0);
        chk("halt_busy", busy, 0);
        pulse_clr();
        send_word(8'h5A, w);
        chk("halt_resume_wait", w, 0);
`else
        send_word(8'h5A, w);
        chk("nohalt_wait", w, WORD_W);
`endif
        wait_idle();
        pulse_clr();

        // cfg_we while busy is ignored
        cfg(4'b1001, 8'd0);
        send_word(8'b1001_0010, w);
        tick();
        cfg_we = 1'b1; cfg_pattern = 4'b0000; cfg_threshold = 8'd5;
        tick();
        cfg_we = 1'b0;
        wait_idle();
        chk("busy_cfg_count", match_count, 2);

        // reset during bit 4 aborts the word
        send_word(8'hFF, w);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_bit_valid", bit_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        tick();
        chk("abort_bit_valid2", bit_valid, 0);

        // saturation with irq disabled
        cfg(4'b0000, 8'd0);
        repeat (40) send_word(8'h00, w);
        wait_idle();
        tick();
        chk("sat_count", match_count, 255);
        chk("sat_irq", irq, 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
